// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stop/flush controller: stage indices,
// default parameter values and the hold-counter width.
package pipe_ctrl_pkg;

    localparam int STG_PC     = 0;
    localparam int STG_BTB    = 1;
    localparam int STG_ICACHE = 2;
    localparam int STG_PRED   = 3;
    localparam int STG_FTQ    = 4;
    localparam int STG_ISQ    = 5;
    localparam int STG_DEC    = 6;
    localparam int STG_RAT    = 7;
    localparam int STG_ISSUE  = 8;
    localparam int STG_EXE    = 9;
    localparam int STG_MEM    = 10;
    localparam int STG_ROB    = 11;

    localparam int DEF_NSTAGE = 16;
    localparam int DEF_FRONT  = 6;
    localparam int DEF_HOLD   = 2;
    localparam int DEF_WDOG_W = 10;

    localparam int HOLD_W = 4;

endpackage

// File: rtl/pipe_ctrl_suffix_or.sv
// Suffix OR: out[j] is set when any input bit at index j or above is set,
// i.e. a request from an older stage propagates to every younger stage.
module pipe_ctrl_suffix_or #(
    parameter int N = 16
) (
    input  logic [N-1:0] in,
    output logic [N-1:0] out
);

    for (genvar j = 0; j < N; j++) begin : gSfx
        assign out[j] = |in[N-1:j];
    end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Per-stage Stop/Flash generation with flush hold, sticky frontend trap,
// Stop[0] watchdog and stall perf counter.
module pipe_ctrl_gen
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = DEF_NSTAGE,
    parameter int FRONT  = DEF_FRONT,
    parameter int HOLD   = DEF_HOLD,
    parameter int WDOG_W = DEF_WDOG_W
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic [NSTAGE-1:0] StallReq,
    input  logic [NSTAGE-1:0] RedirReq,
    input  logic              ROBredir,
    input  logic              TrapReq,
    output logic [NSTAGE-1:0] Stop,
    output logic [NSTAGE-1:0] Flash,
    output logic              TrapPend,
    output logic              WdogErr,
    output logic [31:0]       StallCnt
);

    localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(HOLD - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;
    localparam logic [WDOG_W-1:0] WDOG_PRE = WDOG_MAX - WDOG_W'(1);

    logic [NSTAGE-1:0] stallOr;
    logic [NSTAGE-1:0] redirOr;
    logic [NSTAGE-1:0] flushNow;
    logic [NSTAGE-1:0] flashInt;
    logic [NSTAGE-1:0] stopInt;
    logic [NSTAGE-1:0] frontMask;
    logic [NSTAGE-1:0] holdMask;
    logic [HOLD_W-1:0] holdCnt;
    logic              holdAct;
    logic              trapLatch;
    logic              trapActive;
    logic [WDOG_W-1:0] wdogCnt;
    logic              unusedRedir0;

    assign unusedRedir0 = RedirReq[0];

    pipe_ctrl_suffix_or #(.N(NSTAGE)) uStallOr (
        .in  (StallReq),
        .out (stallOr)
    );

    // Shifted by one so a redirect at stage i flushes only the younger stages.
    pipe_ctrl_suffix_or #(.N(NSTAGE)) uRedirOr (
        .in  ({1'b0, RedirReq[NSTAGE-1:1]}),
        .out (redirOr)
    );

    always_comb begin
        frontMask = '0;
        for (int j = 0; j < NSTAGE; j++) begin
            frontMask[j] = (j < FRONT);
        end
    end

    assign flushNow   = redirOr | {NSTAGE{ROBredir}};
    assign holdAct    = (holdCnt != '0);
    assign flashInt   = flushNow | (holdMask & {NSTAGE{holdAct}});
    assign trapActive = (TrapReq | trapLatch) & ~ROBredir;
    assign stopInt    = (stallOr | (frontMask & {NSTAGE{trapActive}})) & ~flashInt;

    // Reset forces everything flushed and nothing held, independent of state.
    assign Flash    = Rest ? flashInt : '1;
    assign Stop     = Rest ? stopInt  : '0;
    assign TrapPend = trapLatch;

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            holdMask <= '0;
            holdCnt  <= '0;
        end else if (|flushNow) begin
            holdMask <= (holdAct ? holdMask : '0) | flushNow;
            holdCnt  <= HOLD_LD;
        end else if (holdAct) begin
            holdCnt <= holdCnt - HOLD_W'(1);
            if (holdCnt == HOLD_W'(1)) holdMask <= '0;
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest)         trapLatch <= 1'b0;
        else if (ROBredir) trapLatch <= 1'b0;
        else if (TrapReq)  trapLatch <= 1'b1;
    end

    // Error is flagged on the edge where the counter lands on all-ones.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            wdogCnt <= '0;
            WdogErr <= 1'b0;
        end else if (stopInt[0]) begin
            if (wdogCnt != WDOG_MAX) wdogCnt <= wdogCnt + WDOG_W'(1);
            if (wdogCnt >= WDOG_PRE) WdogErr <= 1'b1;
        end else begin
            wdogCnt <= '0;
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest)           StallCnt <= '0;
        else if (stopInt[0]) StallCnt <= StallCnt + 32'd1;
    end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge of the same cycle.
module tb_pipe_ctrl_gen;

    localparam int NSTAGE = 16;

    logic              Clk = 1'b0;
    logic              Rest;
    logic [NSTAGE-1:0] StallReq;
    logic [NSTAGE-1:0] RedirReq;
    logic              ROBredir;
    logic              TrapReq;
    logic [NSTAGE-1:0] Stop;
    logic [NSTAGE-1:0] Flash;
    logic              TrapPend;
    logic              WdogErr;
    logic [31:0]       StallCnt;

    int nRun  = 0;
    int nFail = 0;

    pipe_ctrl_gen #(.NSTAGE(NSTAGE), .FRONT(6), .HOLD(2), .WDOG_W(4)) dut (
        .Clk      (Clk),
        .Rest     (Rest),
        .StallReq (StallReq),
        .RedirReq (RedirReq),
        .ROBredir (ROBredir),
        .TrapReq  (TrapReq),
        .Stop     (Stop),
        .Flash    (Flash),
        .TrapPend (TrapPend),
        .WdogErr  (WdogErr),
        .StallCnt (StallCnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nRun++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle with the given inputs, then settle to mid-cycle.
    task automatic cyc(input logic [15:0] st, input logic [15:0] rd, input logic rob, input logic trp);
        @(posedge Clk);
        #1;
        StallReq = st;
        RedirReq = rd;
        ROBredir = rob;
        TrapReq  = trp;
        @(negedge Clk);
    endtask

    task automatic so(input string tag, input logic [15:0] eStop, input logic [15:0] eFlash);
        chk({tag, ".stop"},  {16'h0, Stop},  {16'h0, eStop});
        chk({tag, ".flash"}, {16'h0, Flash}, {16'h0, eFlash});
    endtask

    initial begin
        Rest = 1'b0;
        StallReq = '0;
        RedirReq = '0;
        ROBredir = 1'b0;
        TrapReq  = 1'b0;
        repeat (2) @(negedge Clk);
        so("rst", 16'h0000, 16'hFFFF);
        chk("rst.trapPend", {31'h0, TrapPend}, 32'd0);
        chk("rst.wdogErr",  {31'h0, WdogErr},  32'd0);
        chk("rst.stallCnt", StallCnt, 32'd0);
        @(posedge Clk);
        #1 Rest = 1'b1;
        @(negedge Clk);
        so("idle", 16'h0000, 16'h0000);

        // Stall at stage 8 stops 8 and every younger stage.
        cyc(16'h0100, 16'h0, 1'b0, 1'b0); so("stall8", 16'h01FF, 16'h0000);
        cyc(16'h0000, 16'h0, 1'b0, 1'b0); so("stall8.after", 16'h0000, 16'h0000);
        cyc(16'h8000, 16'h0, 1'b0, 1'b0); so("stall15", 16'hFFFF, 16'h0000);

        // Redirect at stage 10 flushes 0..9 for two cycles.
        cyc(16'h0000, 16'h0400, 1'b0, 1'b0); so("redir.c1", 16'h0000, 16'h03FF);
        cyc(16'h0000, 16'h0000, 1'b0, 1'b0); so("redir.c2", 16'h0000, 16'h03FF);
        cyc(16'h0000, 16'h0000, 1'b0, 1'b0); so("redir.c3", 16'h0000, 16'h0000);

        // Redirect bit 0 has no younger stages.
        cyc(16'h0000, 16'h0001, 1'b0, 1'b0); so("redir0", 16'h0000, 16'h0000);

        // Flush dominates stop on overlapping stages.
        cyc(16'h0100, 16'h0040, 1'b0, 1'b0); so("mix.c1", 16'h01C0, 16'h003F);
        cyc(16'h0000, 16'h0000, 1'b0, 1'b0); so("mix.c2", 16'h0000, 16'h003F);
        cyc(16'h0000, 16'h0000, 1'b0, 1'b0); so("mix.c3", 16'h0000, 16'h0000);

        // Re-flush during hold reloads the counter.
        cyc(16'h0000, 16'h0400, 1'b0, 1'b0); so("reflush.c1", 16'h0000, 16'h03FF);
        cyc(16'h0000, 16'h0010, 1'b0, 1'b0); so("reflush.c2", 16'h0000, 16'h03FF);
        cyc(16'h0000, 16'h0000, 1'b0, 1'b0); so("reflush.c3", 16'h0000, 16'h03FF);
        cyc(16'h0000, 16'h0000, 1'b0, 1'b0); so("reflush.c4", 16'h0000, 16'h0000);

        // Trap: frontend stop in the request cycle, latch visible the next.
        cyc(16'h0000, 16'h0, 1'b0, 1'b1); so("trap.c1", 16'h003F, 16'h0000);
        chk("trap.c1.pend", {31'h0, TrapPend}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(16'h0000, 16'h0, 1'b0, 1'b0); so("trap.idle", 16'h003F, 16'h0000);
            chk("trap.idle.pend", {31'h0, TrapPend}, 32'd1);
        end
        cyc(16'h0000, 16'h0, 1'b1, 1'b0); so("rob.c1", 16'h0000, 16'hFFFF);
        cyc(16'h0000, 16'h0, 1'b0, 1'b0); so("rob.c2", 16'h0000, 16'hFFFF);
        chk("rob.c2.pend", {31'h0, TrapPend}, 32'd0);
        cyc(16'h0000, 16'h0, 1'b0, 1'b0); so("rob.c3", 16'h0000, 16'h0000);

        // Trap and ROB redirect together: redirect wins.
        cyc(16'h0000, 16'h0, 1'b1, 1'b1); so("both.c1", 16'h0000, 16'hFFFF);
        cyc(16'h0000, 16'h0, 1'b0, 1'b0); so("both.c2", 16'h0000, 16'hFFFF);
        chk("both.c2.pend", {31'h0, TrapPend}, 32'd0);
        cyc(16'h0000, 16'h0, 1'b0, 1'b0); so("both.c3", 16'h0000, 16'h0000);

        // Clean counters before the watchdog run.
        @(posedge Clk);
        #1 Rest = 1'b0;
        @(posedge Clk);
        #1 Rest = 1'b1;
        @(negedge Clk);
        chk("rst2.stallCnt", StallCnt, 32'd0);

        for (int k = 1; k <= 16; k++) begin
            cyc(16'h0001, 16'h0, 1'b0, 1'b0);
            if (k == 15) chk("wdog.c15", {31'h0, WdogErr}, 32'd0);
            if (k == 16) chk("wdog.c16", {31'h0, WdogErr}, 32'd1);
        end
        cyc(16'h0000, 16'h0, 1'b0, 1'b0);
        chk("wdog.sticky", {31'h0, WdogErr}, 32'd1);
        chk("wdog.stallCnt", StallCnt, 32'd16);

        // Reset mid-hold with a pending trap clears everything.
        cyc(16'h0000, 16'h0, 1'b0, 1'b1);
        cyc(16'h0000, 16'h0400, 1'b0, 1'b0);
        chk("pre.pend", {31'h0, TrapPend}, 32'd1);
        #1 Rest = 1'b0;
        RedirReq = '0;
        #1;
        so("midrst", 16'h0000, 16'hFFFF);
        chk("midrst.pend", {31'h0, TrapPend}, 32'd0);
        chk("midrst.wdog", {31'h0, WdogErr},  32'd0);
        chk("midrst.cnt",  StallCnt, 32'd0);
        @(posedge Clk);
        #1 Rest = 1'b1;
        @(negedge Clk);
        so("rel.c1", 16'h0000, 16'h0000);
        chk("rel.pend", {31'h0, TrapPend}, 32'd0);
        cyc(16'h0000, 16'h0, 1'b0, 1'b0); so("rel.c2", 16'h0000, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
